// File: rtl/tt_um_aes_decrypt_stream_if.sv
// Tiny Tapeout pin bundle for the byte-serial AES-128 decrypt stream.
// The harness side drives ena/ui_in/uio_in; the design drives uo_out/uio_out/uio_oe.
interface tt_um_aes_decrypt_stream_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (output ena, ui_in, uio_in, input uo_out, uio_out, uio_oe);
  modport slave  (input ena, ui_in, uio_in, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/tt_um_aes_decrypt_stream.sv
// Byte-serial AES-128 decrypt front end: LOAD 16 cipher bytes, settle the combinational
// aes_decrypt core for CALC_CYCLES (1..15), SEND 16 plaintext bytes. Define AES_DEC_KEY_LOAD_EN for a loadable key.
module tt_um_aes_decrypt_stream #(
  parameter int CALC_CYCLES = 2
) (
  input logic                       clk,
  input logic                       rst_n,
  tt_um_aes_decrypt_stream_if.slave bus
);

  typedef enum logic [1:0] {LOAD, CALC, SEND} state_t;

  localparam logic [127:0] FIXED_KEY   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [3:0]   SETTLE_LAST = 4'(CALC_CYCLES - 1);

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254; zero maps to zero as the S-box requires.
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] p, r;
    p = a;
    r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] v;
    v = ginv(b);
    return v ^ rotl(v, 1) ^ rotl(v, 2) ^ rotl(v, 3) ^ rotl(v, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return ginv(rotl(b, 1) ^ rotl(b, 3) ^ rotl(b, 6) ^ 8'h05);
  endfunction

  // The AES_Decrypt core: full key expansion plus ten inverse rounds, purely combinational.
  function automatic logic [127:0] aes_decrypt(input logic [127:0] ct, input logic [127:0] k);
    logic [31:0] w [44];
    logic [7:0]  s [16];
    logic [7:0]  t [16];
    logic [7:0]  rcon;
    logic [127:0] res;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[32*(3-i) +: 32];
    for (int i = 4; i < 44; i++) begin
      if (i % 4 == 0) begin
        w[i] = w[i-4] ^ {sbox(w[i-1][23:16]) ^ rcon, sbox(w[i-1][15:8]),
                         sbox(w[i-1][7:0]), sbox(w[i-1][31:24])};
        rcon = xt(rcon);
      end else begin
        w[i] = w[i-4] ^ w[i-1];
      end
    end
    for (int i = 0; i < 16; i++) s[i] = ct[8*(15-i) +: 8] ^ w[40 + i/4][8*(3 - i%4) +: 8];
    for (int r = 9; r >= 0; r--) begin
      for (int i = 0; i < 16; i++)
        t[i] = inv_sbox(s[(i % 4) + 4 * (((i / 4) - (i % 4) + 4) % 4)]) ^ w[4*r + i/4][8*(3 - i%4) +: 8];
      if (r != 0) begin
        for (int c = 0; c < 4; c++) begin
          s[4*c]   = gmul(t[4*c], 8'h0e) ^ gmul(t[4*c+1], 8'h0b) ^ gmul(t[4*c+2], 8'h0d) ^ gmul(t[4*c+3], 8'h09);
          s[4*c+1] = gmul(t[4*c], 8'h09) ^ gmul(t[4*c+1], 8'h0e) ^ gmul(t[4*c+2], 8'h0b) ^ gmul(t[4*c+3], 8'h0d);
          s[4*c+2] = gmul(t[4*c], 8'h0d) ^ gmul(t[4*c+1], 8'h09) ^ gmul(t[4*c+2], 8'h0e) ^ gmul(t[4*c+3], 8'h0b);
          s[4*c+3] = gmul(t[4*c], 8'h0b) ^ gmul(t[4*c+1], 8'h0d) ^ gmul(t[4*c+2], 8'h09) ^ gmul(t[4*c+3], 8'h0e);
        end
      end else begin
        s = t;
      end
    end
    for (int i = 0; i < 16; i++) res[8*(15-i) +: 8] = s[i];
    return res;
  endfunction

  state_t       state, state_nxt;
  logic [3:0]   byte_cnt, settle_cnt;
  logic [127:0] cipher, out_buf, key, plain;
  logic         in_valid, out_ready, key_sel;
  logic         in_ready, out_valid, busy;
  logic         take_cipher, give_byte, settle_done;
  logic         unused_bits;

  assign in_valid  = bus.uio_in[0];
  assign out_ready = bus.uio_in[1];

  assign take_cipher = (state == LOAD) && in_valid && !key_sel;
  assign give_byte   = (state == SEND) && out_ready;
  assign settle_done = (state == CALC) && (settle_cnt == SETTLE_LAST);

  // Only cipher and key feed this path; both are frozen for the whole CALC window.
  assign plain = aes_decrypt(cipher, key);

`ifdef AES_DEC_KEY_LOAD_EN
  logic [3:0] key_cnt;
  logic       take_key;

  assign key_sel     = bus.uio_in[4];
  assign take_key    = (state == LOAD) && in_valid && key_sel;
  assign unused_bits = ^{bus.ena, bus.uio_in[7:5], bus.uio_in[3:2]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key     <= FIXED_KEY;
      key_cnt <= 4'd0;
    end else if (take_key) begin
      key[8*(15 - int'(key_cnt)) +: 8] <= bus.ui_in;
      key_cnt                          <= key_cnt + 4'd1;
    end
  end
`else
  assign key_sel     = 1'b0;
  assign key         = FIXED_KEY;
  assign unused_bits = ^{bus.ena, bus.uio_in[7:2]};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignment so every flop samples the pre-edge value of its inputs.
    if (!rst_n) state <= LOAD;
    else        state <= state_nxt;
  end

  always_comb begin
    // NOTE: default assignment first, so no path through the case can infer a latch.
    state_nxt = state;
    unique case (state)
      LOAD:    if (take_cipher && byte_cnt == 4'hf) state_nxt = CALC;
      CALC:    if (settle_done) state_nxt = SEND;
      SEND:    if (give_byte && byte_cnt == 4'hf) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  always_comb begin
    in_ready  = (state == LOAD);
    out_valid = (state == SEND);
    busy      = (state == CALC);
  end

  // byte_cnt is shared: input position in LOAD, output position in SEND; it wraps to 0 after 16.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the wide buffers are reset on purpose: a partial block must never leak and uo_out must read 0.
      byte_cnt   <= 4'd0;
      settle_cnt <= 4'd0;
      cipher     <= '0;
      out_buf    <= '0;
    end else begin
      if (take_cipher || give_byte) byte_cnt <= byte_cnt + 4'd1;
      if (take_cipher) cipher[8*(15 - int'(byte_cnt)) +: 8] <= bus.ui_in;
      if (state == CALC) settle_cnt <= settle_done ? 4'd0 : settle_cnt + 4'd1;
      // Sixteen shifts drain the buffer to zero, which is what clears uo_out back in LOAD.
      if (settle_done)    out_buf <= plain;
      else if (give_byte) out_buf <= {out_buf[119:0], 8'h00};
    end
  end

  assign bus.uo_out  = out_buf[127:120];
  assign bus.uio_out = {2'b00, busy, 1'b0, out_valid, in_ready, 2'b00};
  assign bus.uio_oe  = 8'b0010_1100;

endmodule

// File: tb/tb_tt_um_aes_decrypt_stream.sv
// Bench for tt_um_aes_decrypt_stream: random plaintexts are encrypted by a forward AES model here,
// streamed through the decryptor, and must come back unchanged; handshake timing is checked per block.
module tb_tt_um_aes_decrypt_stream;

  localparam int           CALC    = 2;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tt_um_aes_decrypt_stream_if bus ();
  tt_um_aes_decrypt_stream #(.CALC_CYCLES(CALC)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic in_ready, out_valid, busy;
  assign in_ready  = bus.uio_out[2];
  assign out_valid = bus.uio_out[3];
  assign busy      = bus.uio_out[5];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- forward AES-128 reference model ----------------
  logic [7:0] sbox_tab [256];

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] c, inv, s;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int b = 0; b < 8; b++)
        s[b] = inv[b] ^ inv[(b+4)%8] ^ inv[(b+5)%8] ^ inv[(b+6)%8] ^ inv[(b+7)%8] ^ c[b];
      sbox_tab[x] = s;
    end
  endtask

  function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] k);
    logic [7:0] w [176];
    logic [7:0] st [16];
    logic [7:0] sh [16];
    logic [7:0] t [4];
    logic [7:0] rc, tmp;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) w[i] = k[8*(15-i) +: 8];
    rc = 8'h01;
    for (int i = 16; i < 176; i += 4) begin
      for (int j = 0; j < 4; j++) t[j] = w[i-4+j];
      if (i % 16 == 0) begin
        tmp  = t[0];
        t[0] = sbox_tab[t[1]] ^ rc;
        t[1] = sbox_tab[t[2]];
        t[2] = sbox_tab[t[3]];
        t[3] = sbox_tab[tmp];
        rc   = gf_mul(rc, 8'h02);
      end
      for (int j = 0; j < 4; j++) w[i+j] = w[i-16+j] ^ t[j];
    end
    for (int i = 0; i < 16; i++) st[i] = pt[8*(15-i) +: 8] ^ w[i];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) sh[i] = sbox_tab[st[(i % 4) + 4 * (((i / 4) + (i % 4)) % 4)]];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          st[4*c]   = gf_mul(sh[4*c], 8'h02) ^ gf_mul(sh[4*c+1], 8'h03) ^ sh[4*c+2] ^ sh[4*c+3];
          st[4*c+1] = sh[4*c] ^ gf_mul(sh[4*c+1], 8'h02) ^ gf_mul(sh[4*c+2], 8'h03) ^ sh[4*c+3];
          st[4*c+2] = sh[4*c] ^ sh[4*c+1] ^ gf_mul(sh[4*c+2], 8'h02) ^ gf_mul(sh[4*c+3], 8'h03);
          st[4*c+3] = gf_mul(sh[4*c], 8'h03) ^ sh[4*c+1] ^ sh[4*c+2] ^ gf_mul(sh[4*c+3], 8'h02);
        end
      end else begin
        st = sh;
      end
      for (int i = 0; i < 16; i++) st[i] = st[i] ^ w[16*r + i];
    end
    for (int i = 0; i < 16; i++) res[8*(15-i) +: 8] = st[i];
    return res;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic drive(input bit vld, input bit rdy, input bit ks, input logic [7:0] b);
    bus.uio_in = {3'b000, ks, 2'b00, rdy, vld};
    bus.ui_in  = b;
  endtask

  // Streams one block; called #1 after an edge. in_mode 0 = in_valid held, 1 = every other cycle.
  // in_valid is also raised during CALC to prove it is ignored there.
  task automatic run_block(input logic [127:0] ct, input int in_mode, input int stall_at,
                           input int stall_len, input int stop_after,
                           output logic [127:0] pt, output int lat, output int busy_n,
                           output int first, output int acc16, output int send_n,
                           output bit hold_err, output bit calc_err, output bit end_ok);
    int cyc, in_idx, out_idx, stalls;
    bit vld, rdy, acc, cons, held_v;
    logic [7:0] held;
    cyc = 0; in_idx = 0; out_idx = 0; stalls = 0; held_v = 0; held = 8'h00;
    pt = '0; lat = -1; busy_n = 0; first = -1; acc16 = -1; send_n = 0;
    hold_err = 0; calc_err = 0; end_ok = 0;
    while (out_idx < stop_after && cyc < 400) begin
      if (held_v && out_valid && bus.uo_out !== held) hold_err = 1;
      if (busy) begin
        busy_n++;
        if (in_ready || out_valid) calc_err = 1;
      end
      if (out_valid) send_n++;
      if (acc16 >= 0 && lat < 0 && out_valid) lat = cyc - acc16;
      vld = ((in_idx < 16) && (in_mode == 0 || cyc % 2 == 0)) || busy;
      rdy = 1'b1;
      if (out_valid && out_idx == stall_at && stalls < stall_len) begin
        rdy = 1'b0;
        stalls++;
      end
      acc  = vld && in_ready;
      cons = rdy && out_valid;
      if (cons) pt[8*(15-out_idx) +: 8] = bus.uo_out;
      held_v = out_valid && !rdy;
      held   = bus.uo_out;
      drive(vld, rdy, 1'b0, (vld && in_idx < 16) ? ct[8*(15-in_idx) +: 8] : 8'($urandom));
      @(posedge clk);
      #1;
      cyc++;
      if (acc) begin
        in_idx++;
        if (first < 0) first = cyc;
        if (in_idx == 16) acc16 = cyc;
      end
      if (cons) out_idx++;
    end
    end_ok = in_ready && !out_valid;
  endtask

  typedef struct {
    logic [127:0] ct;
    logic [127:0] pt;
    int           in_mode;
    int           stall_at;
    int           stall_len;
  } vec_t;

  vec_t         vecs [6];
  logic [127:0] got, rpt;
  int           lat, busy_n, first, acc16, send_n;
  bit           hold_err, calc_err, end_ok;

  task automatic load_key(input logic [127:0] k);
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, 1'b1, k[8*(15-i) +: 8]);
      @(posedge clk);
      #1;
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ena = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    build_sbox();

    vecs[0] = '{ct: FIPS_CT, pt: FIPS_PT, in_mode: 0, stall_at: 99, stall_len: 0};
    vecs[1] = '{ct: FIPS_CT, pt: FIPS_PT, in_mode: 1, stall_at: 7,  stall_len: 5};
    for (int i = 2; i < 6; i++) begin
      rpt = {$urandom, $urandom, $urandom, $urandom};
      vecs[i] = '{ct: aes_enc(rpt, FIPS_KEY), pt: rpt, in_mode: i % 2,
                  stall_at: (i == 3) ? 0 : int'($urandom_range(1, 15)), stall_len: (i == 2) ? 0 : 3};
    end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset uo_out", bus.uo_out, 8'h00);
    check("reset uio_out", bus.uio_out, 8'b0000_0100);
    check("uio_oe", bus.uio_oe, 8'b0010_1100);
    rst_n = 1'b1;

    // Table-driven blocks, streamed back to back
    for (int i = 0; i < 6; i++) begin
      run_block(vecs[i].ct, vecs[i].in_mode, vecs[i].stall_at, vecs[i].stall_len, 16,
                got, lat, busy_n, first, acc16, send_n, hold_err, calc_err, end_ok);
      check($sformatf("vec%0d plaintext", i), got, vecs[i].pt);
      check($sformatf("vec%0d out_valid latency", i), lat, CALC);
      check($sformatf("vec%0d busy cycles", i), busy_n, CALC);
      check($sformatf("vec%0d first accept cycle", i), first, 1);
      check($sformatf("vec%0d load cycles", i), acc16, (vecs[i].in_mode == 0) ? 16 : 31);
      check($sformatf("vec%0d send cycles", i), send_n, 16 + vecs[i].stall_len);
      check($sformatf("vec%0d stalled byte held", i), hold_err, 1'b0);
      check($sformatf("vec%0d calc handshakes low", i), calc_err, 1'b0);
      check($sformatf("vec%0d in_ready as out_valid falls", i), end_ok, 1'b1);
    end

    // Reset after 9 input bytes, then a clean block
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 1'b1, 1'b0, 8'($urandom));
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #2;
    check("mid-load reset uo_out", bus.uo_out, 8'h00);
    check("mid-load reset uio_out", bus.uio_out, 8'b0000_0100);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_block(FIPS_CT, 0, 99, 0, 16, got, lat, busy_n, first, acc16, send_n, hold_err, calc_err, end_ok);
    check("after mid-load reset plaintext", got, FIPS_PT);

    // Reset in the middle of SEND must clear uo_out
    run_block(FIPS_CT, 0, 99, 0, 3, got, lat, busy_n, first, acc16, send_n, hold_err, calc_err, end_ok);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    check("partial send first bytes", got[127:104], 24'h001122);
    check("uo_out before send reset", bus.uo_out, 8'h33);
    rst_n = 1'b0;
    #2;
    check("mid-send reset uo_out", bus.uo_out, 8'h00);
    check("mid-send reset uio_out", bus.uio_out, 8'b0000_0100);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rpt = {$urandom, $urandom, $urandom, $urandom};
    run_block(aes_enc(rpt, FIPS_KEY), 1, 4, 2, 16, got, lat, busy_n, first, acc16, send_n,
              hold_err, calc_err, end_ok);
    check("after mid-send reset plaintext", got, rpt);

`ifdef AES_DEC_KEY_LOAD_EN
    load_key(FIPS_KEY);
    run_block(FIPS_CT, 0, 99, 0, 16, got, lat, busy_n, first, acc16, send_n, hold_err, calc_err, end_ok);
    check("loaded key plaintext", got, FIPS_PT);
    load_key('0);
    run_block(FIPS_CT, 0, 99, 0, 16, got, lat, busy_n, first, acc16, send_n, hold_err, calc_err, end_ok);
    check("zero key changes output", got != FIPS_PT, 1'b1);
    rpt = {$urandom, $urandom, $urandom, $urandom};
    run_block(aes_enc(rpt, '0), 0, 2, 2, 16, got, lat, busy_n, first, acc16, send_n,
              hold_err, calc_err, end_ok);
    check("zero key random plaintext", got, rpt);
`endif

    drive(1'b0, 1'b0, 1'b0, 8'h00);
    @(posedge clk);
    #1;
    check("idle uio_out", bus.uio_out, 8'b0000_0100);
    check("idle uo_out", bus.uo_out, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tt_um_aes_decrypt_stream.md
# tt_um_aes_decrypt_stream

Byte-serial AES-128 decryption front end for the Tiny Tapeout harness, the receive-side counterpart of the encrypt top-level. It collects a 16-byte ciphertext block over `ui_in` with a valid/ready handshake. It then holds the block stable on the existing combinational `AES_Decrypt` core for a fixed multicycle settle window, and streams the 16 plaintext bytes out on `uo_out` with a second valid/ready handshake.

## Interface
- `CALC_CYCLES`, default 2: settle cycles allowed for the combinational decrypt path; legal range 1..15.
- `clk`  in  1  system clock, all state on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `ena`  in  1  harness enable; no functional effect.
- `ui_in`  in  8  ciphertext (or key) byte.
- `uio_in`  in  8  [0] in_valid, [1] out_ready, [4] key_sel (macro only); other bits ignored.
- `uo_out`  out  8  current plaintext byte; registered.
- `uio_out`  out  8  [2] in_ready, [3] out_valid, [5] busy; all other bits 0.
- `uio_oe`  out  8  constant 8'b0010_1100.

## Operation
- States: LOAD, CALC, SEND.
- LOAD:
  - in_ready=1.
  - A byte is accepted on an edge with in_valid=1.
  - The first byte accepted goes to cipher[127:120], the 16th to cipher[7:0]; a 4-bit byte counter tracks position.
  - The edge accepting the 16th byte clears the counter and moves to CALC.
- CALC:
  - busy=1, in_ready=0, out_valid=0; cipher register held constant.
  - A settle counter counts edges. On the CALC_CYCLES-th edge, the `AES_Decrypt(cipher, key)` output is latched into the 128-bit out buffer and the state moves to SEND.
- SEND:
  - out_valid=1; uo_out = out_buf[127:120].
  - A byte is consumed on an edge with out_ready=1: out buffer shifts left 8 and the counter increments.
  - The edge consuming the 16th byte moves to LOAD and clears uo_out to 0.
- Key: fixed 128'h000102030405060708090a0b0c0d0e0f unless the macro below is defined.
- in_valid outside LOAD and out_ready outside SEND are ignored.
- Reset (any time, including mid-block):
  - state=LOAD, all counters 0, cipher/out buffer 0, uo_out=0.
  - Outputs during reset: in_ready=1, out_valid=0, busy=0.
  - Partial blocks are discarded.

## Timing
- Input throughput: 1 byte/cycle while in_valid is held.
- Latency: out_valid rises exactly CALC_CYCLES cycles after the edge accepting byte 16.
- Output throughput: 1 byte/cycle while out_ready is held.
- Minimum block period: 16 + CALC_CYCLES + 16 cycles.
- Stalls: in_valid or out_ready low holds all state unchanged, with no byte lost or duplicated.
- After the last output byte, in_ready is 1 on the same cycle out_valid falls; the next block can start immediately.
- The `AES_Decrypt` path is a declared multicycle path of CALC_CYCLES; only cipher and key feed it, and both are stable throughout CALC.

## Configuration
- `AES_DEC_KEY_LOAD_EN` defined:
  - 128-bit key register, reset to the fixed key above.
  - In LOAD, a byte accepted with key_sel=1 shifts into the key register, first byte to key[127:120], using a separate 4-bit key counter.
  - Key bytes do not advance the ciphertext counter. A key load interrupted by a cipher byte keeps its partial progress.
  - The key is used at the next CALC latch.
- `AES_DEC_KEY_LOAD_EN` undefined: key is the constant; key_sel ignored; every accepted byte is ciphertext.

## Test plan
- Reset, then stream 69 c4 e0 d8 6a 7b 04 30 d8 cd b7 80 70 b4 c5 5a with in_valid held and out_ready=1 -> out_valid rises 2 cycles after byte 16; uo_out sequence 00 11 22 … ee ff on consecutive cycles.
- Same block with in_valid toggled every other cycle and out_ready low for 5 cycles mid-stream -> identical plaintext; uo_out holds its byte while stalled.
- Assert rst_n low after 9 input bytes, then send a full block -> correct plaintext; no residue from the partial block. During reset: uo_out=0, out_valid=0, in_ready=1.
- out_ready and in_valid held high during CALC -> no byte consumed and no extra input accepted; busy=1 for exactly CALC_CYCLES cycles.
- Two blocks back-to-back -> second block starts loading the cycle after the 16th output byte; both plaintexts correct.
- With `AES_DEC_KEY_LOAD_EN`: load key 000102…0f byte-wise with key_sel=1, then send 69c4e0d86a7b0430d8cdb78070b4c55a -> 00112233445566778899aabbccddeeff. Then load key 00…00 and send the same block -> output differs from 00112233….
